// File: rtl/line_refill_memory.sv
// line_refill_memory: word-addressed memory model that serves critical-word-first 4-word line refills and write-through stores
module line_refill_memory #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_req,
   input  logic [31:0] rd_addr,
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data,
   output logic [31:0] memory_word,
   output logic [2:0]  counter,
   output logic        word_valid,
   output logic        done,
   output logic        busy
);
   localparam int LW = LATENCY > 1 ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

   state_t state, n_state;
   logic [31:0] mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-3:0] base, n_base;
   logic [1:0] off, n_off, k;
   logic [LW-1:0] lat, n_lat;
   logic emit;
   logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
   logic [31:0] n_word;
   logic [2:0] n_cnt;
   logic unused_bits;

   assign wr_idx = wr_addr[DEPTH_LOG2-1:0];
   assign unused_bits = ^{rd_addr[31:DEPTH_LOG2], wr_addr[31:DEPTH_LOG2]};

   // state and registered outputs; the counter output doubles as the beat index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         memory_word <= '0;
         counter     <= 3'd7;
         word_valid  <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
         base        <= '0;
         off         <= '0;
         lat         <= '0;
      end else begin
         state       <= n_state;
         memory_word <= n_word;
         counter     <= n_cnt;
         word_valid  <= emit;
         done        <= n_state == DONE;
         busy        <= n_state != IDLE;
         base        <= n_base;
         off         <= n_off;
         lat         <= n_lat;
      end
   end

   // next phase: a request is only taken in IDLE, and a burst always runs to DONE
   always_comb begin
      n_state = state;
      case (state)
         IDLE:    n_state = rd_req ? (LATENCY == 0 ? BURST : WAIT) : IDLE;
         WAIT:    n_state = lat == '0 ? BURST : WAIT;
         BURST:   n_state = counter == 3'd3 ? DONE : BURST;
         default: n_state = IDLE;
      endcase
   end

   // next output values: beat address wraps within the line, a same-edge write wins over the array
   always_comb begin
      emit   = (state == IDLE && rd_req && LATENCY == 0) || (state == WAIT && lat == '0) ||
               (state == BURST && counter != 3'd3);
      n_base = state == IDLE ? rd_addr[DEPTH_LOG2-1:2] : base;
      n_off  = state == IDLE ? rd_addr[1:0] : off;
      k      = state == BURST ? counter[1:0] + 2'd1 : 2'd0;
      rd_idx = {n_base, n_off + k};
      n_word = emit ? ((wr_en && wr_idx == rd_idx) ? wr_data : mem[rd_idx]) : memory_word;
      n_cnt  = emit ? {1'b0, k} : n_state == DONE ? 3'd4 : n_state == IDLE ? 3'd7 : counter;
      n_lat  = state == IDLE ? LW'(LATENCY - 1) : state == WAIT ? lat - LW'(1) : lat;
   end

   // storage is never reset; writes land in any state
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end
endmodule

// File: tb/tb_line_refill_memory.sv
// tb_line_refill_memory: directed checks of refill timing, wrap order, write-first and reset abort
module tb_line_refill_memory;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_req = 1'b0, rd_req0 = 1'b0;
   logic [31:0] rd_addr = '0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_addr = '0, wr_data = '0;
   logic [31:0] word, word0;
   logic [2:0]  cnt, cnt0;
   logic        valid, valid0, done, done0, busy, busy0;
   int total = 0, bad = 0;
   logic [31:0] a [4];

   line_refill_memory #(.DEPTH_LOG2(8), .LATENCY(3)) dut (
      .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .memory_word(word), .counter(cnt),
      .word_valid(valid), .done(done), .busy(busy));

   line_refill_memory #(.DEPTH_LOG2(8), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst), .rd_req(rd_req0), .rd_addr(rd_addr), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .memory_word(word0), .counter(cnt0),
      .word_valid(valid0), .done(done0), .busy(busy0));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   initial begin
      a[0] = 32'hA0A0_0000; a[1] = 32'hA1A1_0001; a[2] = 32'hA2A2_0002; a[3] = 32'hA3A3_0003;
      tick(); tick();
      rst = 1'b0;
      chk("rst_cnt", {29'd0, cnt}, 32'd7);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_word", word, 32'd0);
      chk("rst_cnt0", {29'd0, cnt0}, 32'd7);
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_addr = 32'd8 + i; wr_data = a[i];
         tick();
      end
      wr_en = 1'b0;
      tick();
      chk("idle_busy", {31'd0, busy}, 32'd0);
      // aligned refill, latency 3
      rd_addr = 32'd8; rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("t0_busy", {31'd0, busy}, 32'd1);
      chk("t0_valid", {31'd0, valid}, 32'd0);
      tick(); tick();
      chk("t2_valid", {31'd0, valid}, 32'd0);
      chk("t2_cnt", {29'd0, cnt}, 32'd7);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("al_word", word, a[i]);
         chk("al_cnt", {29'd0, cnt}, i);
         chk("al_valid", {31'd0, valid}, 32'd1);
      end
      tick();
      chk("al_done", {31'd0, done}, 32'd1);
      chk("al_done_cnt", {29'd0, cnt}, 32'd4);
      chk("al_done_valid", {31'd0, valid}, 32'd0);
      chk("al_done_word", word, a[3]);
      chk("al_done_busy", {31'd0, busy}, 32'd1);
      tick();
      chk("al_idle_done", {31'd0, done}, 32'd0);
      chk("al_idle_cnt", {29'd0, cnt}, 32'd7);
      chk("al_idle_busy", {31'd0, busy}, 32'd0);
      // critical word first with wrap
      rd_addr = 32'd10; rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      tick(); tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("wrap_word", word, a[(i + 2) % 4]);
         chk("wrap_cnt", {29'd0, cnt}, i);
      end
      tick();
      chk("wrap_done", {31'd0, done}, 32'd1);
      tick();
      // zero latency instance
      rd_addr = 32'd11; rd_req0 = 1'b1;
      tick();
      rd_req0 = 1'b0;
      chk("l0_word0", word0, a[3]);
      chk("l0_cnt0", {29'd0, cnt0}, 32'd0);
      chk("l0_valid0", {31'd0, valid0}, 32'd1);
      for (int i = 1; i < 4; i++) begin
         tick();
         chk("l0_word", word0, a[(i + 3) % 4]);
         chk("l0_cnt", {29'd0, cnt0}, i);
      end
      tick();
      chk("l0_done", {31'd0, done0}, 32'd1);
      chk("l0_done_cnt", {29'd0, cnt0}, 32'd4);
      tick();
      chk("l0_idle_busy", {31'd0, busy0}, 32'd0);
      // write-first on the edge that loads beat 3
      rd_addr = 32'd8; rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      repeat (5) tick();
      chk("wf_beat2", word, a[2]);
      wr_en = 1'b1; wr_addr = 32'd11; wr_data = 32'hDEAD;
      tick();
      wr_en = 1'b0;
      chk("wf_beat3", word, 32'hDEAD);
      chk("wf_cnt3", {29'd0, cnt}, 32'd3);
      tick(); tick();
      rd_addr = 32'd11; rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      repeat (3) tick();
      chk("wf_refill", word, 32'hDEAD);
      repeat (5) tick();
      chk("wf_refill_idle", {31'd0, busy}, 32'd0);
      // held request across DONE, aliased address, request dropped at beat 1
      rd_addr = 32'h0100_0008; rd_req = 1'b1;
      tick();
      repeat (3) tick();
      chk("alias_word", word, a[0]);
      repeat (4) tick();
      chk("hold_done", {31'd0, done}, 32'd1);
      tick();
      chk("hold_gap_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("hold_accept_busy", {31'd0, busy}, 32'd1);
      rd_addr = 32'd4;
      repeat (3) tick();
      chk("hold_b0", word, a[0]);
      rd_req = 1'b0;
      tick();
      chk("drop_b1", word, a[1]);
      chk("drop_cnt1", {29'd0, cnt}, 32'd1);
      tick(); tick();
      chk("drop_b3", word, 32'hDEAD);
      tick();
      chk("drop_done", {31'd0, done}, 32'd1);
      tick();
      // reset mid-burst at beat 2
      rd_addr = 32'd8; rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      repeat (5) tick();
      chk("rb_cnt2", {29'd0, cnt}, 32'd2);
      rst = 1'b1;
      #1;
      chk("rb_cnt", {29'd0, cnt}, 32'd7);
      chk("rb_valid", {31'd0, valid}, 32'd0);
      chk("rb_busy", {31'd0, busy}, 32'd0);
      chk("rb_word", word, 32'd0);
      chk("rb_done", {31'd0, done}, 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rb_no_done", {31'd0, done}, 32'd0);
         chk("rb_no_valid", {31'd0, valid}, 32'd0);
      end
      // contents survive reset
      rd_addr = 32'd9; rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      repeat (3) tick();
      chk("post_rst_word", word, a[1]);
      repeat (5) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
